instr_fetch_unit: RTL and testbench

- Initiator side of the instruction-memory read interface.
- Owns the program counter and drives pc_out into instruction_memory's PC_out.
- Captures the combinational instruction word into a small prefetch FIFO and hands {pc, instr} pairs to decode over a valid/ready handshake.
- Handles branch/jump redirects, FIFO flush and an external halt request.

---
 rtl/if_pkg.sv | 18 +
 rtl/instr_fetch_unit_if.sv | 23 ++
 rtl/if_prefetch_fifo.sv | 56 +++++
 rtl/instr_fetch_unit.sv | 108 ++++++++++
 tb/tb_instr_fetch_unit.sv | 311 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

    localparam int unsigned FETCH_XLEN = 32;
    localparam int unsigned PC_STEP    = 4;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        HALT
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_XLEN-1:0] pc;
        logic [FETCH_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port plus the fetch-to-decode valid/ready handshake.
interface instr_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);

    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] instruction;
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;
    logic            id_ready;

    modport master (
        output pc_out, if_valid, if_pc, if_instr,
        input  instruction, id_ready
    );

    modport slave (
        input  pc_out, if_valid, if_pc, if_instr,
        output instruction, id_ready
    );

endinterface

// File: rtl/if_prefetch_fifo.sv
// Synchronous prefetch FIFO; pointers carry one extra wrap bit so full/empty
// come from comparing the MSBs.
module if_prefetch_fifo #(
    parameter int unsigned DEPTH   = 2,
    parameter type         entry_t = logic
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  logic   pop,
    input  logic   flush,
    input  entry_t wr_data,
    output logic   full,
    output logic   empty,
    output entry_t head
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [DEPTH];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
    end

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign head  = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: PC/FSM control feeding a prefetch FIFO towards decode.
// Optional macro FETCH_MISALIGN_CHECK_EN adds misalign_err and halts on unaligned redirects.
module instr_fetch_unit
    import if_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    instr_fetch_unit_if.master  bus,
    input  logic                redirect_valid,
    input  logic [XLEN-1:0]     redirect_pc,
    input  logic                halt_req,
    output logic                halted
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                misalign_err
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            halted_q, halted_d;
    logic            fifo_full, fifo_empty;
    logic            push, pop;
    fetch_entry_t    wr_entry, head;

`ifdef FETCH_MISALIGN_CHECK_EN
    logic err_q, err_d;
    logic misalign;
    assign misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`endif

    always_comb begin
        pop  = !fifo_empty && bus.id_ready && !redirect_valid;
        push = (state_q == FETCH) && !halt_req && !redirect_valid &&
               (!fifo_full || pop);
        wr_entry.pc    = pc_q;
        wr_entry.instr = bus.instruction;

        pc_d = pc_q;
        if (redirect_valid)  pc_d = redirect_pc & ~XLEN'(3);
        else if (push)       pc_d = pc_q + XLEN'(PC_STEP);

        state_d = state_q;
        if (!redirect_valid) begin
            case (state_q)
                IDLE:    state_d = halt_req ? HALT : FETCH;
                FETCH:   if (halt_req)  state_d = HALT;
                HALT:    if (!halt_req) state_d = FETCH;
                default: state_d = IDLE;
            endcase
        end

`ifdef FETCH_MISALIGN_CHECK_EN
        // A bad target keeps the old PC and pins the FSM in HALT until reset.
        err_d = err_q || misalign;
        if (misalign) pc_d = pc_q;
        if (err_d)    state_d = HALT;
`endif
        halted_d = (state_d == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            halted_q <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            halted_q <= halted_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            err_q    <= err_d;
`endif
        end
    end

    if_prefetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wr_data (wr_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .head    (head)
    );

    assign bus.pc_out   = pc_q;
    assign bus.if_valid = !fifo_empty;
    assign bus.if_pc    = fifo_empty ? '0 : head.pc;
    assign bus.if_instr = fifo_empty ? '0 : head.instr;
    assign halted       = halted_q;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign misalign_err = err_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: expected {pc, instr} pairs are queued
// when a scenario starts and popped on each decode handshake.
module tb_instr_fetch_unit;
    import if_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        halted;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign_err;
`endif

    int unsigned  tests_run = 0;
    int unsigned  tests_failed = 0;
    fetch_entry_t sb[$];

    always #5 clk = ~clk;

    instr_fetch_unit_if #(.XLEN(32)) bus ();

    instr_fetch_unit #(
        .XLEN       (32),
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .bus            (bus),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .halted         (halted)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .misalign_err   (misalign_err)
`endif
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    always_comb bus.instruction = mem_word(bus.pc_out);

    function automatic fetch_entry_t mk(input logic [31:0] pc);
        fetch_entry_t e;
        e.pc    = pc;
        e.instr = mem_word(pc);
        return e;
    endfunction

    task automatic do_reset(input logic ready);
        @(negedge clk);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        bus.id_ready   = ready;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        halt_req       = 1'b0;
        bus.id_ready   = 1'b1;
        rst_n          = 1'b0;
        #12;
        tests_run++;
        if (bus.pc_out !== 32'h0) begin tests_failed++; $display("FAIL reset_pc: got %h expected 00000000", bus.pc_out); end
        tests_run++;
        if (bus.if_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", bus.if_valid); end
        tests_run++;
        if (bus.if_pc !== 32'h0 || bus.if_instr !== 32'h0) begin
            tests_failed++; $display("FAIL reset_head: got pc=%h instr=%h expected 0/0", bus.if_pc, bus.if_instr);
        end
        tests_run++;
        if (halted !== 1'b0) begin tests_failed++; $display("FAIL reset_halted: got %b expected 0", halted); end
`ifdef FETCH_MISALIGN_CHECK_EN
        tests_run++;
        if (misalign_err !== 1'b0) begin tests_failed++; $display("FAIL reset_err: got %b expected 0", misalign_err); end
`endif
    endtask

    task automatic test_stream;
        fetch_entry_t e;
        do_reset(1'b1);
        for (int i = 0; i < 6; i++) sb.push_back(mk(32'(i * 4)));
        @(negedge clk);
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.pc_out !== 32'h0) begin
            tests_failed++; $display("FAIL stream_first: got valid=%b pc_out=%h expected 0/00000000", bus.if_valid, bus.pc_out);
        end
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.if_valid !== 1'b1) begin tests_failed++; $display("FAIL stream_gap: cycle %0d got valid=%b expected 1", i, bus.if_valid); end
            tests_run++;
            if (bus.pc_out !== 32'((i + 1) * 4)) begin
                tests_failed++; $display("FAIL stream_pc_out: got %h expected %h", bus.pc_out, 32'((i + 1) * 4));
            end
            if (bus.if_valid && bus.id_ready && sb.size() > 0) begin
                e = sb.pop_front();
                tests_run++;
                if (bus.if_pc !== e.pc || bus.if_instr !== e.instr) begin
                    tests_failed++; $display("FAIL stream_entry: got %h/%h expected %h/%h", bus.if_pc, bus.if_instr, e.pc, e.instr);
                end
            end
        end
        tests_run++;
        if (sb.size() != 0) begin tests_failed++; $display("FAIL stream_drain: got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_stall;
        fetch_entry_t e;
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) sb.push_back(mk(32'(i * 4)));
        repeat (5) @(negedge clk);
        tests_run++;
        if (bus.pc_out !== 32'h8) begin tests_failed++; $display("FAIL stall_pc_out: got %h expected 00000008", bus.pc_out); end
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== mem_word(32'h0)) begin
            tests_failed++; $display("FAIL stall_head: got v=%b %h/%h expected 1 00000000/%h", bus.if_valid, bus.if_pc, bus.if_instr, mem_word(32'h0));
        end
        bus.id_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (bus.if_valid !== 1'b1) begin tests_failed++; $display("FAIL stall_gap: cycle %0d got valid=%b expected 1", i, bus.if_valid); end
            if (bus.if_valid && sb.size() > 0) begin
                e = sb.pop_front();
                tests_run++;
                if (bus.if_pc !== e.pc || bus.if_instr !== e.instr) begin
                    tests_failed++; $display("FAIL stall_entry: got %h/%h expected %h/%h", bus.if_pc, bus.if_instr, e.pc, e.instr);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (sb.size() != 0) begin tests_failed++; $display("FAIL stall_drain: got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_redirect;
        fetch_entry_t e;
        do_reset(1'b0);
        repeat (5) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h40;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.pc_out !== 32'h40) begin
            tests_failed++; $display("FAIL redirect_flush: got valid=%b pc_out=%h expected 0/00000040", bus.if_valid, bus.pc_out);
        end
        for (int i = 0; i < 3; i++) sb.push_back(mk(32'h40 + 32'(i * 4)));
        @(negedge clk);
        bus.id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (bus.if_valid !== 1'b1) begin tests_failed++; $display("FAIL redirect_gap: cycle %0d got valid=%b expected 1", i, bus.if_valid); end
            if (bus.if_valid && sb.size() > 0) begin
                e = sb.pop_front();
                tests_run++;
                if (bus.if_pc !== e.pc || bus.if_instr !== e.instr) begin
                    tests_failed++; $display("FAIL redirect_entry: got %h/%h expected %h/%h", bus.if_pc, bus.if_instr, e.pc, e.instr);
                end
            end
            @(negedge clk);
        end
        tests_run++;
        if (sb.size() != 0) begin tests_failed++; $display("FAIL redirect_drain: got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_halt;
        fetch_entry_t e;
        logic        h_exp [7] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic        v_exp [7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [31:0] p_exp [7] = '{32'h8, 32'h8, 32'h8, 32'h8, 32'h8, 32'hC, 32'h10};
        do_reset(1'b0);
        for (int i = 0; i < 4; i++) sb.push_back(mk(32'(i * 4)));
        repeat (3) @(negedge clk);
        halt_req     = 1'b1;
        bus.id_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tests_run++;
            if (halted !== h_exp[i]) begin tests_failed++; $display("FAIL halt_flag: cycle %0d got %b expected %b", i, halted, h_exp[i]); end
            tests_run++;
            if (bus.if_valid !== v_exp[i] || bus.pc_out !== p_exp[i]) begin
                tests_failed++; $display("FAIL halt_state: cycle %0d got v=%b pc_out=%h expected %b/%h", i, bus.if_valid, bus.pc_out, v_exp[i], p_exp[i]);
            end
            if (bus.if_valid && sb.size() > 0) begin
                e = sb.pop_front();
                tests_run++;
                if (bus.if_pc !== e.pc || bus.if_instr !== e.instr) begin
                    tests_failed++; $display("FAIL halt_entry: got %h/%h expected %h/%h", bus.if_pc, bus.if_instr, e.pc, e.instr);
                end
            end
            if (i == 3) halt_req = 1'b0;
            @(negedge clk);
        end
        tests_run++;
        if (sb.size() != 0) begin tests_failed++; $display("FAIL halt_drain: got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_wrap;
        fetch_entry_t e;
        do_reset(1'b1);
        @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        tests_run++;
        if (bus.if_valid !== 1'b0 || bus.pc_out !== 32'hFFFF_FFFC) begin
            tests_failed++; $display("FAIL wrap_redirect: got valid=%b pc_out=%h expected 0/fffffffc", bus.if_valid, bus.pc_out);
        end
        sb.push_back(mk(32'hFFFF_FFFC));
        sb.push_back(mk(32'h0));
        sb.push_back(mk(32'h4));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests_run++;
            if (bus.if_valid !== 1'b1) begin tests_failed++; $display("FAIL wrap_gap: cycle %0d got valid=%b expected 1", i, bus.if_valid); end
            if (bus.if_valid && sb.size() > 0) begin
                e = sb.pop_front();
                tests_run++;
                if (bus.if_pc !== e.pc || bus.if_instr !== e.instr) begin
                    tests_failed++; $display("FAIL wrap_entry: got %h/%h expected %h/%h", bus.if_pc, bus.if_instr, e.pc, e.instr);
                end
            end
        end
        tests_run++;
        if (sb.size() != 0) begin tests_failed++; $display("FAIL wrap_drain: got %0d left expected 0", sb.size()); end
    endtask

    task automatic test_misalign;
        do_reset(1'b0);
        repeat (3) @(negedge clk);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h42;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        tests_run++;
        if (misalign_err !== 1'b1 || halted !== 1'b1 || bus.if_valid !== 1'b0) begin
            tests_failed++; $display("FAIL misalign_flags: got err=%b halted=%b valid=%b expected 1/1/0", misalign_err, halted, bus.if_valid);
        end
        tests_run++;
        if (bus.pc_out !== 32'h8) begin tests_failed++; $display("FAIL misalign_pc: got %h expected 00000008", bus.pc_out); end
        bus.id_ready = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (misalign_err !== 1'b1 || halted !== 1'b1 || bus.if_valid !== 1'b0) begin
            tests_failed++; $display("FAIL misalign_sticky: got err=%b halted=%b valid=%b expected 1/1/0", misalign_err, halted, bus.if_valid);
        end
`else
        tests_run++;
        if (bus.pc_out !== 32'h40 || bus.if_valid !== 1'b0) begin
            tests_failed++; $display("FAIL misalign_clear: got pc_out=%h valid=%b expected 00000040/0", bus.pc_out, bus.if_valid);
        end
        @(negedge clk);
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h40 || bus.if_instr !== mem_word(32'h40)) begin
            tests_failed++; $display("FAIL misalign_target: got v=%b %h/%h expected 1 00000040/%h", bus.if_valid, bus.if_pc, bus.if_instr, mem_word(32'h40));
        end
`endif
    endtask

    task automatic test_reset_mid;
        do_reset(1'b1);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (bus.pc_out !== 32'h0 || bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || halted !== 1'b0) begin
            tests_failed++; $display("FAIL midreset: got pc_out=%h valid=%b if_pc=%h halted=%b expected 0/0/0/0", bus.pc_out, bus.if_valid, bus.if_pc, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        tests_run++;
        if (bus.if_valid !== 1'b1 || bus.if_pc !== 32'h0 || bus.if_instr !== mem_word(32'h0)) begin
            tests_failed++; $display("FAIL midreset_restart: got v=%b %h/%h expected 1 00000000/%h", bus.if_valid, bus.if_pc, bus.if_instr, mem_word(32'h0));
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_halt();
        test_wrap();
        test_misalign();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
